pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, 32, PC and target width in bits.
REQ-002 Parameter RESET_PC, 32'h0000_0000, PC value loaded at reset.
REQ-003 Parameter STEP, 4, sequential PC increment.
REQ-004 Parameter NUM_SRC, 4, number of redirect sources (>=2); SEL_W = clog2(NUM_SRC).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 stall  input  1  hold PC; no sequential advance.
REQ-008 redirect_valid  input  1  a redirect is requested this cycle.
REQ-009 redirect_sel  input  SEL_W  index of the redirect source to take.
REQ-010 redirect_target  input  NUM_SRC*XLEN  flattened targets; source i occupies bits [i*XLEN +: XLEN].
REQ-011 halt_req  input  1  halt request (ecall with exit code).
REQ-012 fetch_ready  input  1  fetch stage accepts the current PC.
REQ-013 fetch_valid  output  1  pc is valid for fetch.
REQ-014 pc  output  XLEN  current PC register.
REQ-015 pc_plus_step  output  XLEN  pc + STEP, combinational.
REQ-016 halted  output  1  block is in HALTED.
REQ-017 redirect_err  output  1  one-cycle pulse: redirect_sel >= NUM_SRC.
REQ-018 fetch_count  output  XLEN  number of accepted fetch handshakes.

Function
REQ-019 The FSM SHALL have the states BOOT, RUN and HALTED.
REQ-020 Transitions: BOOT->RUN unconditionally after one cycle; RUN->HALTED when halt_req=1; HALTED is sticky until reset.
REQ-021 fetch_valid SHALL be 1 only in RUN and only while stall=0.
REQ-022 A handshake SHALL occur on any cycle with fetch_valid=1 and fetch_ready=1.
REQ-023 PC update priority in RUN: halt_req (hold) > valid redirect (load) > handshake (pc+STEP) > otherwise hold.
REQ-024 A valid redirect loads redirect_target[redirect_sel] with bit 0 cleared on the next edge, overriding stall and fetch_ready.
REQ-025 A redirect with redirect_sel >= NUM_SRC SHALL be ignored, and redirect_err SHALL pulse for exactly the next cycle.
REQ-026 pc+STEP SHALL wrap modulo 2^XLEN; no overflow flag.
REQ-027 fetch_count SHALL increment by 1 per handshake, wrap modulo 2^XLEN, and hold in BOOT and HALTED.
REQ-028 In BOOT and HALTED, pc SHALL hold; redirect and stall inputs SHALL be ignored.
REQ-029 halt_req together with redirect_valid in the same cycle: halt wins, pc holds and the redirect is discarded.
REQ-030 Latency: every pc change is visible one cycle after the qualifying input; pc_plus_step has zero latency.

Reset
REQ-031 Asserting reset at any time, mid-operation included, SHALL immediately force: state=BOOT, pc=RESET_PC, fetch_valid=0, halted=0, redirect_err=0, fetch_count=0.
REQ-032 After reset deasserts, the first rising edge SHALL move the FSM to RUN; fetch_valid rises in that cycle if stall=0.

Structure
REQ-033 A package pc_gen_pkg SHALL hold the FSM state enum (BOOT, RUN, HALTED) and the default parameter constants.
REQ-034 The STEP adder SHALL be a parametrised sub-module pc_adder (XLEN-wide, a+b, no carry out), instantiated once.
REQ-035 The redirect source select SHALL be an index mux over the flattened bus, not a chained 2:1 mux tree.

Verification
REQ-036 Reset then free run: fetch_ready=1, stall=0, 4 cycles after BOOT -> pc = 0, 4, 8, 12; fetch_count=4.
REQ-037 Redirect during stall: pc=0x10, stall=1, redirect_valid=1, sel=2, target[2]=0x201 -> next pc=0x200, redirect_err=0.
REQ-038 Bad select: NUM_SRC=3, sel=3, redirect_valid=1 -> pc advances normally, redirect_err=1 for exactly one cycle.
REQ-039 Halt vs redirect: halt_req=1 and redirect_valid=1 at pc=0x40 -> pc stays 0x40, halted=1, fetch_valid=0, fetch_count frozen.
REQ-040 Wrap: RESET_PC=0xFFFF_FFFC, one handshake -> pc=0x0000_0000.
REQ-041 Reset mid-run at pc=0x80, fetch_count=5 -> pc=RESET_PC and fetch_count=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and default constants for the program counter generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          STEP_DEF     = 4;
    localparam int          NUM_SRC_DEF  = 4;

endpackage

// File: rtl/pc_adder.sv
// Plain XLEN-wide adder; the carry out is dropped so results wrap.
module pc_adder #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: boot/run/halt control, redirects and a
// fetch handshake counter.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int             XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int             STEP     = STEP_DEF,
    parameter int             NUM_SRC  = NUM_SRC_DEF,
    localparam int            SEL_W    = $clog2(NUM_SRC)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic [SEL_W-1:0]        redirect_sel,
    input  logic [NUM_SRC*XLEN-1:0] redirect_target,
    input  logic                    halt_req,
    input  logic                    fetch_ready,
    output logic                    fetch_valid,
    output logic [XLEN-1:0]         pc,
    output logic [XLEN-1:0]         pc_plus_step,
    output logic                    halted,
    output logic                    redirect_err,
    output logic [XLEN-1:0]         fetch_count
);

    localparam int NENT = 1 << SEL_W;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] tgt_arr [NENT];
    logic [XLEN-1:0] sel_tgt;
    logic            sel_ok;
    logic            handshake;

    // Pad the table to a power of two so the index never leaves range.
    for (genvar g = 0; g < NENT; g++) begin : g_src
        if (g < NUM_SRC) begin : g_v
            assign tgt_arr[g] = redirect_target[g*XLEN +: XLEN];
        end else begin : g_p
            assign tgt_arr[g] = '0;
        end
    end

    assign sel_tgt = tgt_arr[redirect_sel];
    assign sel_ok  = 32'(redirect_sel) < NUM_SRC;

    pc_adder #(
        .XLEN (XLEN)
    ) u_adder (
        .a_i   (pc_q),
        .b_i   (XLEN'(STEP)),
        .sum_o (pc_plus_step)
    );

    assign fetch_valid  = (state_q == RUN) && !stall;
    assign handshake    = fetch_valid && fetch_ready;
    assign pc           = pc_q;
    assign halted       = (state_q == HALTED);
    assign redirect_err = err_q;
    assign fetch_count  = cnt_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (handshake) cnt_d = cnt_q + XLEN'(1);
                if (halt_req) begin
                    state_d = HALTED;
                end else if (redirect_valid && sel_ok) begin
                    pc_d = {sel_tgt[XLEN-1:1], 1'b0};
                end else begin
                    err_d = redirect_valid;
                    if (handshake) pc_d = pc_plus_step;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Randomised and directed bench for pc_gen with an in-bench reference
// model; two instances cover default and 3-source / wrapping configs.
module tb_pc_gen;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stall, rv, halt, rdy;
    logic [1:0]   sel;
    logic [127:0] tgt;

    logic        fv_a, hl_a, err_a, fv_b, hl_b, err_b;
    logic [31:0] pc_a, pps_a, cnt_a, pc_b, pps_b, cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen u_a (
        .clk (clk), .reset (rst_n), .stall (stall),
        .redirect_valid (rv), .redirect_sel (sel),
        .redirect_target (tgt), .halt_req (halt),
        .fetch_ready (rdy), .fetch_valid (fv_a), .pc (pc_a),
        .pc_plus_step (pps_a), .halted (hl_a),
        .redirect_err (err_a), .fetch_count (cnt_a)
    );

    pc_gen #(
        .NUM_SRC (3), .RESET_PC (32'hFFFF_FFFC)
    ) u_b (
        .clk (clk), .reset (rst_n), .stall (stall),
        .redirect_valid (rv), .redirect_sel (sel),
        .redirect_target (tgt[95:0]), .halt_req (halt),
        .fetch_ready (rdy), .fetch_valid (fv_b), .pc (pc_b),
        .pc_plus_step (pps_b), .halted (hl_b),
        .redirect_err (err_b), .fetch_count (cnt_b)
    );

    // st: 0 = boot, 1 = run, 2 = halted
    typedef struct {
        int          st;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        err;
    } mst_t;

    mst_t m_a, m_b;

    function automatic mst_t mreset(logic [31:0] rpc);
        mst_t n;
        n.st = 0; n.pc = rpc; n.cnt = 0; n.err = 1'b0;
        return n;
    endfunction

    function automatic mst_t mstep(mst_t s, int ns);
        mst_t        n = s;
        bit          run = (s.st == 1);
        bit          hs = run && !stall && rdy;
        bit          bad = int'(sel) >= ns;
        logic [31:0] w = tgt[int'(sel)*32 +: 32];
        n.err = run && rv && !halt && bad;
        if (hs) n.cnt = s.cnt + 1;
        if (s.st == 0) n.st = 1;
        else if (run) begin
            if (halt) n.st = 2;
            else if (rv && !bad) n.pc = w & 32'hFFFF_FFFE;
            else if (hs) n.pc = s.pc + 32'd4;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= mreset(32'h0);
            m_b <= mreset(32'hFFFF_FFFC);
        end else begin
            m_a <= mstep(m_a, 4);
            m_b <= mstep(m_b, 3);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a.fetch_valid", 32'(fv_a), 32'(m_a.st == 1 && !stall));
        chk("a.pc", pc_a, m_a.pc);
        chk("a.pc_plus_step", pps_a, m_a.pc + 32'd4);
        chk("a.halted", 32'(hl_a), 32'(m_a.st == 2));
        chk("a.redirect_err", 32'(err_a), 32'(m_a.err));
        chk("a.fetch_count", cnt_a, m_a.cnt);
        chk("b.fetch_valid", 32'(fv_b), 32'(m_b.st == 1 && !stall));
        chk("b.pc", pc_b, m_b.pc);
        chk("b.pc_plus_step", pps_b, m_b.pc + 32'd4);
        chk("b.halted", 32'(hl_b), 32'(m_b.st == 2));
        chk("b.redirect_err", 32'(err_b), 32'(m_b.err));
        chk("b.fetch_count", cnt_b, m_b.cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; rv = 1'b0; halt = 1'b0;
        rdy = 1'b0; sel = 2'd0; tgt = '0;
        #12;
        chk("rst pc", pc_a, 32'h0);
        chk("rst cnt", cnt_a, 32'h0);
        chk("rst fv", 32'(fv_a), 32'h0);
        chk("rst pc_b", pc_b, 32'hFFFF_FFFC);

        @(negedge clk);
        rst_n = 1'b1;
        rdy = 1'b1;
        step();
        chk("run0 pc", pc_a, 32'h0);
        chk("run0 fv", 32'(fv_a), 32'h1);
        step();
        chk("run1 pc", pc_a, 32'h4);
        chk("wrap pc_b", pc_b, 32'h0);
        step();
        chk("run2 pc", pc_a, 32'h8);
        step();
        chk("run3 pc", pc_a, 32'hC);
        step();
        chk("free cnt", cnt_a, 32'd4);
        chk("free pc", pc_a, 32'h10);

        stall = 1'b1; rv = 1'b1; sel = 2'd2;
        tgt[95:64] = 32'h201; tgt[127:96] = 32'h41;
        step();
        chk("stall redir pc", pc_a, 32'h200);
        chk("stall redir err", 32'(err_a), 32'h0);
        chk("stall redir cnt", cnt_a, 32'd4);

        stall = 1'b0; sel = 2'd3;
        step();
        chk("badsel pc_b", pc_b, 32'h204);
        chk("badsel err_b", 32'(err_b), 32'h1);
        chk("sel3 pc_a", pc_a, 32'h40);
        rv = 1'b0; stall = 1'b1;
        step();
        chk("badsel err_b clr", 32'(err_b), 32'h0);

        stall = 1'b0; rdy = 1'b0; halt = 1'b1; rv = 1'b1;
        sel = 2'd1; tgt[63:32] = 32'h999;
        step();
        chk("halt pc", pc_a, 32'h40);
        chk("halt halted", 32'(hl_a), 32'h1);
        chk("halt fv", 32'(fv_a), 32'h0);
        chk("halt cnt", cnt_a, 32'd5);
        halt = 1'b0; rdy = 1'b1; sel = 2'd0;
        step();
        step();
        chk("halted pc", pc_a, 32'h40);
        chk("halted cnt", cnt_a, 32'd5);

        rv = 1'b0; rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        step();
        step();
        step();
        rv = 1'b1; sel = 2'd0; tgt[31:0] = 32'h81;
        step();
        rv = 1'b0; rdy = 1'b0;
        chk("pre-rst pc", pc_a, 32'h80);
        chk("pre-rst cnt", cnt_a, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async pc", pc_a, 32'h0);
        chk("async cnt", cnt_a, 32'h0);
        chk("async fv", 32'(fv_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            step();
            stall = ($urandom_range(0, 3) == 0);
            rdy   = ($urandom_range(0, 3) != 0);
            rv    = ($urandom_range(0, 5) == 0);
            sel   = 2'($urandom_range(0, 3));
            halt  = ($urandom_range(0, 299) == 0);
            if (halt) rdy = 1'b0;
            tgt   = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
        end
        step();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
